if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  fetch address; equals pc.
REQ-006 imem_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid  input  1  read data valid; cannot be back-pressured.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 redirect_valid  input  1  branch/jump redirect; single-cycle pulse.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 inst_valid  output  1  inst/inst_pc are valid for decode.
REQ-012 inst  output  32  instruction to decode and immediate generation.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 id_ready  input  1  decode accepts inst this cycle.

Function
REQ-015 Internal pc register; states REQ, WAIT, KILL; at most one outstanding memory request.
REQ-016 imem_req = (state==REQ) && !redirect_valid && (!inst_valid || id_ready), combinational.
REQ-017 REQ: when imem_req && imem_ready, go to WAIT; otherwise hold REQ.
REQ-018 WAIT, imem_rvalid, no redirect: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4, go to REQ.
REQ-019 Transfer occurs when inst_valid && id_ready; inst_valid clears next cycle unless refilled in the same cycle per REQ-018.
REQ-020 inst and inst_pc hold their last values while inst_valid is low, or while inst_valid && !id_ready.
REQ-021 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 redirect_valid has top priority in every state: pc<=redirect_pc, inst_valid<=0 next cycle.
REQ-023 Redirect in REQ: no request is issued that cycle; stay in REQ.
REQ-024 Redirect in WAIT without imem_rvalid: go to KILL.
REQ-025 Redirect in WAIT with imem_rvalid the same cycle: the response is discarded; go to REQ.
REQ-026 KILL: imem_req=0; the next imem_rvalid is discarded and the state goes to REQ; a redirect in KILL updates pc and stays in KILL.
REQ-027 A discarded response never changes inst, inst_pc, inst_valid, or pc.
REQ-028 Minimum throughput is one instruction per 2 cycles, with zero-wait memory and id_ready held high.

Reset
REQ-029 rst_n low asynchronously forces: pc=RESET_PC, state=REQ, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=32'h0, fetch_misalign=0 (if present).
REQ-030 imem_req is high in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-request (WAIT/KILL) abandons the request; any later imem_rvalid arriving while in REQ is ignored.

Configuration
REQ-032 Macro IF_MISALIGN_EN defined: adds output fetch_misalign (1 bit) and state ERR.
REQ-033 With IF_MISALIGN_EN, a redirect with redirect_pc[1:0]!=0 enters ERR (from KILL, only after the pending response is discarded).
REQ-034 In ERR: fetch_misalign=1, imem_req=0, inst_valid=0; only an aligned redirect exits ERR, going to REQ.
REQ-035 Without IF_MISALIGN_EN, the module loads pc with {redirect_pc[31:2],2'b00} and has no ERR state or fetch_misalign port.

Verification
REQ-036 Reset release, imem_ready=1, 1-cycle rvalid with data 32'h00500093, id_ready=1 -> imem_addr=0, then inst=32'h00500093 with inst_pc=0, then imem_addr=4.
REQ-037 id_ready=0 while inst_valid=1 -> imem_req=0, inst and inst_pc stable; id_ready=1 -> imem_req=1 the same cycle.
REQ-038 Redirect to 32'h100 one cycle after request acceptance, stale rvalid later -> stale data is never presented; next imem_addr=32'h100.
REQ-039 Redirect coincident with rvalid in WAIT -> inst_valid=0 next cycle; next imem_addr=redirect_pc.
REQ-040 pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-041 Redirect to 32'h102: with IF_MISALIGN_EN -> fetch_misalign=1 and no requests until a redirect to 32'h200; without IF_MISALIGN_EN -> imem_addr=32'h100.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a single outstanding memory request.
// A pc register drives instruction memory. One fetched word is buffered for
// decode, and branch/jump redirects kill any in-flight response.
// Optional feature: define IF_MISALIGN_EN to trap misaligned redirect targets.
// This adds an ERR state and a fetch_misalign output.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
`ifdef IF_MISALIGN_EN
    output logic        fetch_misalign,
`endif
    input  logic        id_ready
);

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IF_MISALIGN_EN
    typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_KILL = 2'd2, ST_ERR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_KILL = 2'd2} state_t;
`endif

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        inst_valid_reg, inst_valid_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
    logic [31:0] redirect_target;

`ifdef IF_MISALIGN_EN
    // Misaligned targets are kept as-is so the ERR state can be entered.
    logic redirect_bad;
    assign redirect_target = redirect_pc;
    assign redirect_bad    = (redirect_pc[1:0] != 2'b00);
    assign fetch_misalign  = (state_reg == ST_ERR);
`else
    // The low two bits are forced to zero, so they are intentionally dropped.
    logic redirect_lsb_unused;
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];
`endif

    // A request is only issued when the output buffer will be free next cycle.
    assign imem_req   = (state_reg == ST_REQ) && !redirect_valid && (!inst_valid_reg || id_ready);
    assign imem_addr  = pc_reg;
    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;

    // Next-state logic: redirect first, then normal fetch sequencing.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_valid_next = inst_valid_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;

        if (inst_valid_reg && id_ready) begin
            inst_valid_next = 1'b0;
        end

        if (redirect_valid) begin
            pc_next         = redirect_target;
            inst_valid_next = 1'b0;
            case (state_reg)
                // The outstanding response is still due unless it lands this cycle.
                ST_WAIT: state_next = imem_rvalid ? ST_REQ : ST_KILL;
                // If the pending response coincides with the redirect, it is consumed
                // and dropped here. Otherwise KILL would wait for a beat that never comes.
                ST_KILL: state_next = imem_rvalid ? ST_REQ : ST_KILL;
                default: state_next = ST_REQ;
            endcase
`ifdef IF_MISALIGN_EN
            if (redirect_bad && (state_next == ST_REQ)) begin
                state_next = ST_ERR;
            end
`endif
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (imem_req && imem_ready) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        inst_next       = imem_rdata;
                        inst_pc_next    = pc_reg;
                        inst_valid_next = 1'b1;
                        pc_next         = pc_reg + 32'd4;
                        state_next      = ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (imem_rvalid) begin
`ifdef IF_MISALIGN_EN
                        // A misaligned redirect seen while killing is trapped once the stale beat is gone.
                        state_next = (pc_reg[1:0] != 2'b00) ? ST_ERR : ST_REQ;
`else
                        state_next = ST_REQ;
`endif
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            inst_valid_reg <= 1'b0;
            inst_reg       <= NOP;
            inst_pc_reg    <= 32'h0000_0000;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
        end
    end

endmodule
